// File: rtl/reg_shift_pipe.sv
// reg_shift_pipe
// Elastic valid/ready register pipeline. It carries WIDTH-bit words through
// STAGES register stages. A one-entry skid register sits in front of the
// stages so that in_ready can come straight from a flop.
//
// Ports:
//   clk          - single clock, all state updates on posedge
//   rst_n        - asynchronous, active-low reset
//   in_valid     - upstream word present
//   in_ready     - block can accept a word this cycle (registered)
//   in_data      - upstream word
//   out_valid    - last stage holds a word
//   out_ready    - downstream accepts out_data this cycle
//   out_data     - last-stage word
//   occupancy    - words held (stage valids + skid)
//   overflow_err - sticky: in_valid seen while stalled with the skid full
module reg_shift_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(STAGES+2)-1:0]   occupancy,
    output logic                          overflow_err
);

    localparam int OCC_W = $clog2(STAGES + 2);

    logic [STAGES-1:0] stage_valid;
    logic [WIDTH-1:0]  stage_data [STAGES];
    logic [STAGES-1:0] stage_ready;

    logic              skid_valid;
    logic [WIDTH-1:0]  skid_data;
    logic              skid_valid_next;
    logic              skid_load;
    logic              skid_drain;

    logic              accept;
    logic              src_valid;
    logic [WIDTH-1:0]  src_data;

    // A stage may load when it, or any stage after it, is empty, or when the
    // downstream consumer takes the last word. This is the unrolled form of
    // ready_i = !v_i | ready_{i+1}. It keeps the ready chain free of
    // self-referencing vector bits.
    genvar g;
    for (g = 0; g < STAGES; g++) begin : g_ready
        assign stage_ready[g] = out_ready | ~(&stage_valid[STAGES-1:g]);
    end

    assign accept = in_valid & in_ready;

    // The skid always holds the oldest waiting word, so it has priority
    // over the live input when stage 0 loads.
    assign src_valid = skid_valid | accept;
    assign src_data  = skid_valid ? skid_data : in_data;

    // A new word goes into the skid if stage 0 cannot take it, or if the
    // skid is handing its word to stage 0 in this same cycle.
    assign skid_load  = accept & (~stage_ready[0] | skid_valid);
    assign skid_drain = skid_valid & stage_ready[0];

    always_comb begin
        skid_valid_next = skid_valid;
        if (skid_load) begin
            skid_valid_next = 1'b1;
        end else if (skid_drain) begin
            skid_valid_next = 1'b0;
        end
    end

    // Stage registers: each stage shifts forward whenever its ready is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stage_data[i] <= '0;
            end
        end else begin
            if (stage_ready[0]) begin
                stage_valid[0] <= src_valid;
                stage_data[0]  <= src_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (stage_ready[i]) begin
                    stage_valid[i] <= stage_valid[i-1];
                    stage_data[i]  <= stage_data[i-1];
                end
            end
        end
    end

    // Skid register, registered in_ready and the sticky overflow flag.
    // in_ready is derived from the next skid state. This means a full skid
    // is never advertised as having room.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid   <= 1'b0;
            skid_data    <= '0;
            in_ready     <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            skid_valid <= skid_valid_next;
            if (skid_load) begin
                skid_data <= in_data;
            end
            in_ready <= ~skid_valid_next;
            if (in_valid && !in_ready && skid_valid) begin
                overflow_err <= 1'b1;
            end
        end
    end

    // Occupancy counts held words straight from the valid flops. It
    // therefore changes only on an edge, and drops to zero as soon as reset
    // is asserted.
    always_comb begin
        occupancy = OCC_W'(skid_valid);
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(stage_valid[i]);
        end
    end

    assign out_valid = stage_valid[STAGES-1];
    assign out_data  = stage_data[STAGES-1];

endmodule
